// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and bundle layouts for the fetch/decode boundary.
package if_stage_pkg;

  localparam int BR_BUS_WD = 34;
  localparam int FS_TO_DS_BUS_WD = 64;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: next-PC, one-outstanding SRAM fetch, delay-slot
// branch redirect and a one-entry buffer against decode back-pressure.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t   br;
  fs_to_ds_t fs_bus;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        started_q, started_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic        slot_done_q, slot_done_d;
  logic        hold_q, hold_d;
  logic [31:0] hold_addr_q, hold_addr_d;

  logic        br_new, pend_eff, slot_eff;
  logic        stall_blk, if_free, ready_go;
  logic        accept, handoff;
  logic [31:0] tgt_eff, nextpc;

  assign br = br_bus;

  assign ready_go       = inst_sram_data_ok || buf_valid_q;
  assign fs_to_ds_valid = !reset && fs_valid_q && ready_go;
  assign handoff        = fs_to_ds_valid && ds_allowin;
  assign if_free        = !fs_valid_q || handoff;

  // A fresh branch is honoured in the cycle decode presents it.
  assign br_new   = br.taken && !br.stall && !br_pending_q;
  assign pend_eff = br_pending_q || br_new;
  assign slot_eff = br_pending_q ? slot_done_q : fs_valid_q;
  assign tgt_eff  = br_pending_q ? br_target_q : br.target;

  assign stall_blk = br.stall && (fs_valid_q || slot_done_q);

  always_comb begin
    nextpc = RESET_PC;
    if (pend_eff && slot_eff) begin
      nextpc = tgt_eff;
    end else if (started_q) begin
      nextpc = fs_pc_q + 32'd4;
    end
  end

  // A raised request keeps its address until accepted.
  assign inst_sram_req   = !reset && (hold_q || (if_free && !stall_blk));
  assign inst_sram_addr  = hold_q ? hold_addr_q : nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign accept = inst_sram_req && inst_sram_addr_ok;

  assign fs_bus.inst  = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_bus.pc    = fs_pc_q;
  assign fs_to_ds_bus = fs_bus;

  always_comb begin
    fs_valid_d   = fs_valid_q;
    fs_pc_d      = fs_pc_q;
    started_d    = started_q;
    buf_valid_d  = buf_valid_q;
    inst_buf_d   = inst_buf_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    slot_done_d  = slot_done_q;
    hold_d       = inst_sram_req && !inst_sram_addr_ok;
    hold_addr_d  = inst_sram_addr;

    if (accept) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = inst_sram_addr;
      started_d  = 1'b1;
    end else if (handoff) begin
      fs_valid_d = 1'b0;
    end

    if (handoff) begin
      buf_valid_d = 1'b0;
    end else if (inst_sram_data_ok && fs_valid_q && !ds_allowin) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end

    if (pend_eff) begin
      if (accept && slot_eff) begin
        br_pending_d = 1'b0;
        slot_done_d  = 1'b0;
      end else begin
        br_pending_d = 1'b1;
        br_target_d  = tgt_eff;
        slot_done_d  = slot_eff || accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q   <= 1'b0;
      fs_pc_q      <= 32'd0;
      started_q    <= 1'b0;
      buf_valid_q  <= 1'b0;
      inst_buf_q   <= 32'd0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'd0;
      slot_done_q  <= 1'b0;
      hold_q       <= 1'b0;
      hold_addr_q  <= 32'd0;
    end else begin
      fs_valid_q   <= fs_valid_d;
      fs_pc_q      <= fs_pc_d;
      started_q    <= started_d;
      buf_valid_q  <= buf_valid_d;
      inst_buf_q   <= inst_buf_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      slot_done_q  <= slot_done_d;
      hold_q       <= hold_d;
      hold_addr_q  <= hold_addr_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: SRAM and decode models, fetch/delivery scoreboard.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  always #5 clk = ~clk;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'hBFC0_0004) ? 32'h2402_0001 : ~a;
  endfunction

  logic [31:0] exp_f[$];
  logic [31:0] exp_d[$];

  bit          mem_pend;
  logic [31:0] mem_pc;
  bit          ds_v;
  logic [31:0] ds_pc;
  int          aok_dly, aok_cnt;
  bit          br_en;
  logic [31:0] br_pc, br_tgt;
  int          stall_left;
  int          lo_start;
  int          tcyc;
  int          n_hand;
  bit          rst_now;
  bit          bp_chk, st_chk;

  task automatic tick();
    bit          br_vis, acc, hs, req;
    logic [31:0] addr, pc;
    @(negedge clk);
    tcyc++;
    reset = rst_now;
    inst_sram_data_ok = mem_pend && !rst_now;
    inst_sram_rdata = mem_pend ? mem_fn(mem_pc) : 32'hDEAD_BEEF;
    br_vis = br_en && ds_v && (ds_pc == br_pc) && !rst_now;
    br_bus = br_vis ? {stall_left > 0, stall_left == 0, br_tgt} : '0;
    ds_allowin = !(br_vis && stall_left > 0) &&
                 !(tcyc >= lo_start && tcyc < lo_start + 3);
    inst_sram_addr_ok = (aok_cnt >= aok_dly);
    #1;
    req  = inst_sram_req;
    addr = inst_sram_addr;
    acc  = req && inst_sram_addr_ok;
    hs   = fs_to_ds_valid && ds_allowin;
    pc   = fs_to_ds_bus[31:0];
    if (rst_now) begin
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    end else begin
      if (tcyc == 1) begin
        chk("first_req", {31'd0, req}, 32'd1);
        chk("first_addr", addr, 32'hBFC0_0000);
      end
      if (acc && exp_f.size() > 0) chk("fetch", addr, exp_f.pop_front());
      if (hs) begin
        n_hand++;
        if (exp_d.size() > 0) begin
          logic [31:0] e;
          e = exp_d.pop_front();
          chk("pc", pc, e);
          chk("inst", fs_to_ds_bus[63:32], mem_fn(e));
        end
      end
      if (bp_chk && tcyc >= lo_start && tcyc < lo_start + 3) begin
        chk("bp_req", {31'd0, req}, 32'd0);
        chk("bp_valid", {31'd0, fs_to_ds_valid}, 32'd1);
        chk("bp_inst", fs_to_ds_bus[63:32], 32'h2402_0001);
      end
      if (st_chk && br_vis && stall_left > 0)
        chk("stall_req", {31'd0, req}, 32'd0);
    end
    @(posedge clk);
    if (rst_now) begin
      mem_pend = 0;
      ds_v = 0;
      aok_cnt = 0;
    end else begin
      mem_pend = acc;
      if (acc) mem_pc = addr;
      aok_cnt = acc ? 0 : (req ? aok_cnt + 1 : 0);
      if (hs) begin
        ds_v = 1;
        ds_pc = pc;
      end else if (ds_allowin) begin
        ds_v = 0;
      end
      if (br_vis && stall_left > 0) stall_left--;
    end
  endtask

  task automatic do_reset();
    rst_now = 1;
    tick();
    tick();
    rst_now = 0;
    tcyc = 0;
    n_hand = 0;
    aok_cnt = 0;
    exp_f.delete();
    exp_d.delete();
  endtask

  task automatic push3(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    exp_f.push_back(a); exp_f.push_back(b); exp_f.push_back(c);
    exp_d.push_back(a); exp_d.push_back(b); exp_d.push_back(c);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_fetch_left"}, exp_f.size(), 32'd0);
    chk({tag, "_deliv_left"}, exp_d.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ds_allowin = 1'b1;
    br_bus = '0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0;
    mem_pend = 0; mem_pc = '0; ds_v = 0; ds_pc = '0;
    aok_dly = 0; aok_cnt = 0; br_en = 0; br_pc = '0; br_tgt = '0;
    stall_left = 0; lo_start = 1000; tcyc = 0; n_hand = 0;
    rst_now = 0; bp_chk = 0; st_chk = 0;

    // streaming, 1 inst/cycle
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008);
    repeat (5) tick();
    chk("thruput", n_hand, 32'd4);
    drain("seq");

    // decode back-pressure with buffer
    lo_start = 3; bp_chk = 1;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008);
    repeat (8) tick();
    drain("bp");
    lo_start = 1000; bp_chk = 0;

    // taken branch, slot already in IF
    br_en = 1; br_pc = 32'hBFC0_0000; br_tgt = 32'hBFC0_0100;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0100);
    exp_f.push_back(32'hBFC0_0104);
    exp_d.push_back(32'hBFC0_0104);
    repeat (7) tick();
    drain("br_slot");

    // taken branch, IF empty, slow address handshake
    aok_dly = 2;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0100);
    repeat (12) tick();
    drain("br_empty");

    // stalled branch then redirect
    aok_dly = 0; br_tgt = 32'hBFC0_0200; stall_left = 2; st_chk = 1;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0200);
    repeat (7) tick();
    drain("br_stall");
    chk("stall_used", stall_left, 32'd0);
    st_chk = 0;

    // reset while a branch is pending
    aok_dly = 2; br_tgt = 32'hBFC0_0100; stall_left = 0;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0100);
    repeat (6) tick();
    br_en = 0; aok_dly = 0;
    do_reset();
    push3(32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008);
    repeat (6) tick();
    drain("mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
